// File: rtl/msg_frame_tx_pkg.sv
// msg_frame_tx shared definitions: framing bytes, buffer depth, framer states.
// Used by both the transmit framer and the receive-side decoder.
package msg_frame_tx_pkg;

    localparam int         DATAMAXBYTES = 10;
    localparam logic [7:0] SP_SYNC      = 8'h7E;
    localparam logic [7:0] SP_ESC       = 8'h02;
    localparam logic [7:0] SP_END       = 8'h03;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        BCNT = 3'd2,
        BODY = 3'd3,
        TAIL = 3'd4
    } frm_state_t;

    function automatic logic is_special(
        input logic [7:0] b,
        input logic [7:0] s,
        input logic [7:0] e,
        input logic [7:0] t
    );
        return (b == s) || (b == e) || (b == t);
    endfunction

endpackage

// File: rtl/msg_frame_tx_if.sv
// Host-side bundle of msg_frame_tx: payload writes, send request and status.
// master drives requests, slave reports status.
interface msg_frame_tx_if;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       send;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output wr_en, wr_data, send,
        input  busy, done, err
    );

    modport slave (
        input  wr_en, wr_data, send,
        output busy, done, err
    );

endinterface

// File: rtl/msg_frame_tx_uart_tx_ser.sv
// 8N1 serializer, LSB first, one bit per baud_tick.
// Ready on the tick that ends a stop bit so bytes chain without idle bits.
module uart_tx_ser (
    input  logic       CLK,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx_out
);

    logic       active;
    logic [3:0] bitcnt;
    logic [7:0] shreg;

    // bitcnt names the bit on the line: 0 start, 1..8 data, 9 stop
    assign byte_ready = baud_tick & (~active | (bitcnt == 4'd9));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            bitcnt <= 4'd0;
            shreg  <= 8'h00;
            tx_out <= 1'b1;
        end else if (baud_tick) begin
            if (byte_ready && byte_valid) begin
                active <= 1'b1;
                bitcnt <= 4'd0;
                shreg  <= byte_data;
                tx_out <= 1'b0;
            end else if (active) begin
                if (bitcnt == 4'd9) begin
                    active <= 1'b0;
                    tx_out <= 1'b1;
                end else begin
                    bitcnt <= bitcnt + 4'd1;
                    tx_out <= (bitcnt == 4'd8) ? 1'b1 : shreg[0];
                    shreg  <= {1'b0, shreg[7:1]};
                end
            end
        end
    end

endmodule

// File: rtl/msg_frame_tx.sv
// Message framer: buffers payload, emits SYNC, BCNT, escaped body, END
// through the 8N1 serializer; reports busy/done/err.
module msg_frame_tx #(
    parameter int         DATAMAXBYTES = msg_frame_tx_pkg::DATAMAXBYTES,
    parameter logic [7:0] SP_SYNC      = msg_frame_tx_pkg::SP_SYNC,
    parameter logic [7:0] SP_ESC       = msg_frame_tx_pkg::SP_ESC,
    parameter logic [7:0] SP_END       = msg_frame_tx_pkg::SP_END
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       send,
    output logic       tx_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    import msg_frame_tx_pkg::*;

    localparam logic [3:0] MAXB = 4'(DATAMAXBYTES);

    frm_state_t state, state_n;
    logic       esc, esc_n;
    logic       sent, sent_n;
    logic [3:0] idx, idx_n;
    logic [3:0] count, count_n;
    logic [3:0] wptr, wptr_n;
    logic       done_n, err_n;
    logic       wr_ok;

    logic [7:0] mem [DATAMAXBYTES];

    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic [7:0] lit;
    logic       esc_sel;
    logic       hs;

    // Byte offered to the serializer; esc marks the prefix as already sent
    always_comb begin
        lit        = 8'h00;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        esc_sel    = 1'b0;
        unique case (state)
            SYNC: begin
                byte_valid = 1'b1;
                byte_data  = SP_SYNC;
            end
            BCNT: begin
                byte_valid = 1'b1;
                lit        = {4'h0, count};
            end
            BODY: begin
                byte_valid = 1'b1;
                lit        = mem[idx];
            end
            TAIL: begin
                byte_valid = ~sent;
                byte_data  = SP_END;
            end
            default: ;
        endcase
        if (state == BCNT || state == BODY) begin
            esc_sel   = is_special(lit, SP_SYNC, SP_ESC, SP_END) & ~esc;
            byte_data = esc_sel ? SP_ESC : lit;
        end
    end

    assign hs = byte_valid & byte_ready;

    always_comb begin
        state_n = state;
        esc_n   = esc;
        sent_n  = sent;
        idx_n   = idx;
        count_n = count;
        wptr_n  = wptr;
        done_n  = 1'b0;
        err_n   = 1'b0;
        wr_ok   = 1'b0;
        if (state == IDLE) begin
            if (wr_en) begin
                if (count == MAXB) begin
                    err_n = 1'b1;
                end else begin
                    wr_ok   = 1'b1;
                    wptr_n  = wptr + 4'd1;
                    count_n = count + 4'd1;
                end
            end
            // A same-cycle write is already counted in count_n
            if (send) begin
                if (count_n == 4'd0) begin
                    err_n = 1'b1;
                end else begin
                    state_n = SYNC;
                    esc_n   = 1'b0;
                    sent_n  = 1'b0;
                    idx_n   = 4'd0;
                end
            end
        end else begin
            err_n = wr_en;
            unique case (state)
                SYNC: if (hs) state_n = BCNT;
                BCNT, BODY: begin
                    if (hs) begin
                        if (esc_sel) begin
                            esc_n = 1'b1;
                        end else begin
                            esc_n = 1'b0;
                            if (state == BCNT) begin
                                state_n = BODY;
                                idx_n   = 4'd0;
                            end else if (idx == 4'(count - 4'd1)) begin
                                state_n = TAIL;
                            end else begin
                                idx_n = idx + 4'd1;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (hs) begin
                        sent_n = 1'b1;
                    end else if (sent && byte_ready) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        count_n = 4'd0;
                        wptr_n  = 4'd0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            esc   <= 1'b0;
            sent  <= 1'b0;
            idx   <= 4'd0;
            count <= 4'd0;
            wptr  <= 4'd0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            esc   <= esc_n;
            sent  <= sent_n;
            idx   <= idx_n;
            count <= count_n;
            wptr  <= wptr_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) mem[wptr] <= wr_data;
    end

    assign busy = (state != IDLE);

    uart_tx_ser u_ser (
        .CLK        (CLK),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx_out     (tx_out)
    );

endmodule

// File: doc/msg_frame_tx.md
MSG_FRAME_TX -- requirements
Module: msg_frame_tx

Interface
REQ-001 The block SHALL have parameter DATAMAXBYTES, default 10, giving the payload buffer depth in bytes.
REQ-002 The block SHALL have parameter SP_SYNC, default 8'h7E, the frame start byte.
REQ-003 The block SHALL have parameter SP_ESC, default 8'h02, the escape prefix byte.
REQ-004 The block SHALL have parameter SP_END, default 8'h03, the frame tail byte.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port baud_tick, input, 1 bit: one-CLK-cycle bit-rate enable.
REQ-008 The block SHALL have port wr_en, input, 1 bit: writes wr_data into the payload buffer.
REQ-009 The block SHALL have port wr_data, input, 8 bits: the payload byte.
REQ-010 The block SHALL have port send, input, 1 bit: frame start request.
REQ-011 The block SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse when a write or send is rejected.

Function
REQ-015 Frame order on the line SHALL be: SP_SYNC, BCNT, payload bytes in write order, SP_END; BCNT is the number of payload bytes.
REQ-016 Escaping: any BCNT or payload byte equal to SP_SYNC, SP_ESC or SP_END SHALL be sent as SP_ESC followed by the literal byte; the leading SP_SYNC and trailing SP_END SHALL never be escaped.
REQ-017 The framer SHALL have states IDLE, SYNC, BCNT, BODY and TAIL, plus one escape-pending flag. It SHALL move IDLE->SYNC on an accepted send, then SYNC->BCNT->BODY->TAIL->IDLE as each byte finishes.
REQ-018 BODY SHALL stay in BODY until the byte index equals count-1; the escape prefix SHALL NOT advance the index.
REQ-019 Serializer: 8N1, LSB first. Each bit SHALL be held for exactly one baud_tick interval. Bit order: start bit (0), d0..d7, stop bit (1).
REQ-020 Consecutive frame bytes SHALL follow each other with no idle bits; the next start bit begins on the baud_tick that ends the previous stop bit.
REQ-021 Latency: send SHALL be accepted on the CLK edge where it is sampled while not busy; busy SHALL rise on that same edge; the start bit of SP_SYNC SHALL be driven from the first baud_tick after acceptance.
REQ-022 done SHALL pulse for one cycle on the baud_tick that ends the SP_END stop bit; busy SHALL fall on that same edge.
REQ-023 Writes with wr_en=1 while idle SHALL store wr_data at the write pointer and increment it.
REQ-024 A write when the count equals DATAMAXBYTES SHALL be dropped and SHALL pulse err.
REQ-025 A write while busy SHALL be ignored and SHALL pulse err.
REQ-026 send while busy SHALL be ignored with no err.
REQ-027 send with a count of 0 SHALL NOT start a frame and SHALL pulse err.
REQ-028 wr_en and send asserted in the same idle cycle: the write SHALL complete first, and the frame SHALL include that byte.
REQ-029 On done, the write pointer and count SHALL clear to 0; buffer contents need not clear.
REQ-030 Counters: the byte index and count SHALL be 4 bits; the bit counter SHALL be 4 bits (0..9); baud_tick while idle SHALL have no effect.

Reset
REQ-031 On reset=0, the block SHALL immediately and asynchronously set tx_out=1, busy=0, done=0 and err=0, state=IDLE, and clear the escape flag, count, write pointer and bit counter.
REQ-032 A reset mid-frame SHALL abort the frame with no done pulse; the line SHALL return high within the same cycle.
REQ-033 After reset is released, operation SHALL resume on the next CLK edge.

Structure
REQ-034 SP_SYNC, SP_ESC, SP_END, DATAMAXBYTES and the framer state encodings SHALL live in a shared package that the receive-side decoder also uses.
REQ-035 The 8N1 serializer SHALL be the sub-module uart_tx_ser, with ports CLK, reset, baud_tick, byte_valid, byte_data[7:0], byte_ready and tx_out; the framer SHALL hand it bytes via a valid/ready handshake.

Verification
REQ-036 The bench SHALL cover: write 0x41, 0x42, 0x43, then send -> line bytes 7E 02 03 41 42 43 03 (the BCNT value 3 equals SP_END, so it is escaped); done pulses once.
REQ-037 The bench SHALL cover: write 0x7E, 0x55, then send -> line bytes 7E 02 02 02 7E 55 03.
REQ-038 The bench SHALL cover: a single byte 0x41 -> bits on tx_out 0,1,0,0,0,0,0,1,0,1, each lasting one baud_tick interval.
REQ-039 The bench SHALL cover: 11 writes -> err on the 11th write; send -> BCNT 0x0A and 10 payload bytes.
REQ-040 The bench SHALL cover: send with an empty buffer -> err pulse, busy stays 0, tx_out stays 1.
REQ-041 The bench SHALL cover: reset asserted during a BODY byte -> tx_out=1 and busy=0 at once; a new 1-byte frame afterwards goes out correctly.
